// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: one shared hex decoder, a scan counter,
// and a double-buffered display register that only changes at frame boundaries.
module seg_scan_driver #(
  parameter int NDIG           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp,
  input  logic              load,
  input  logic              lzb_en,
  input  logic              blank,
  output logic [6:0]        seg,
  output logic              dot,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
  localparam logic            SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic            AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_OFF = SEG_INV ? 7'h7f : 7'h00;
  localparam logic            DOT_OFF = SEG_INV;
  localparam logic [NDIG-1:0] AN_OFF  = AN_INV ? {NDIG{1'b1}} : {NDIG{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] disp_val_q, disp_val_d;
  logic [NDIG-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIG-1:0] pend_val_q, pend_val_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic              pending_q, pending_d;
  logic              frame_q, frame_d;
  logic [6:0]        seg_q, seg_d;
  logic              dot_q, dot_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic tick;
  logic wrap;

  function automatic logic [6:0] hex_to_lit(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b0111111;
      4'h1: r = 7'b0000110;
      4'h2: r = 7'b1011011;
      4'h3: r = 7'b1001111;
      4'h4: r = 7'b1100110;
      4'h5: r = 7'b1101101;
      4'h6: r = 7'b1111101;
      4'h7: r = 7'b0000111;
      4'h8: r = 7'b1111111;
      4'h9: r = 7'b1101111;
      4'ha: r = 7'b1110111;
      4'hb: r = 7'b1111100;
      4'hc: r = 7'b0111001;
      4'hd: r = 7'b1011110;
      4'he: r = 7'b1111001;
      default: r = 7'b1110001;
    endcase
    return r;
  endfunction

  // Scan timing: idx advances once every SCAN_DIV cycles, wrap marks the frame boundary.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: a load coinciding with the frame boundary bypasses the pending buffer.
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    frame_d    = 1'b0;
    if (wrap && load) begin
      disp_val_d = value;
      disp_dp_d  = dp;
      pend_val_d = value;
      pend_dp_d  = dp;
      pending_d  = 1'b0;
      frame_d    = 1'b1;
    end else if (wrap && pending_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
      frame_d    = 1'b1;
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pending_d  = 1'b1;
    end
  end

  logic [3:0]      nib_sel;
  logic            dp_sel;
  logic [NDIG-1:0] lead_zero;
  logic            zero_run;
  logic            lz_sel;
  logic [NDIG-1:0] an_onehot;
  logic [6:0]      lit;

  // Digit decode from the current idx and committed buffer; registered one cycle later.
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    an_onehot = '0;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run     = zero_run & (disp_val_q[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        nib_sel      = disp_val_q[4*k +: 4];
        dp_sel       = disp_dp_q[k];
        lz_sel       = lead_zero[k];
        an_onehot[k] = 1'b1;
      end
    end
    lit   = (lzb_en && lz_sel) ? 7'b0000000 : hex_to_lit(nib_sel);
    seg_d = SEG_INV ? ~lit : lit;
    dot_d = SEG_INV ? ~dp_sel : dp_sel;
    if (blank) begin
      an_d = AN_OFF;
    end else begin
      an_d = AN_INV ? ~an_onehot : an_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      dot_q      <= DOT_OFF;
      an_q       <= AN_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      dot_q      <= dot_d;
      an_q       <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dot     = dot_q;
  assign an      = an_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4-cycle scan, active-low pins), compared each
// cycle against a cycle-count reference model derived from the scan/commit rules.
module tb_seg_scan_driver;

  localparam int NDIG  = 4;
  localparam int SD    = 4;
  localparam int FRAME = NDIG * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lzb_en;
  logic        blank;
  logic [6:0]  seg;
  logic        dot;
  logic [3:0]  an;
  logic        pending;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  seg_scan_driver #(
    .NDIG(NDIG), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .lzb_en(lzb_en), .blank(blank), .seg(seg), .dot(dot), .an(an),
    .pending(pending), .frame(frame)
  );

  always #5 clk = ~clk;

  // Active-high lit patterns {g..a} for hex digits 0..F.
  logic [6:0] hex_lit [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Reference model: e = clock edges since reset release.
  int          e;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp;
  logic        m_pend, m_frame;

  task automatic m_reset();
    e = 0; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; m_pend = 0; m_frame = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // One clock: drive inputs, predict outputs from pre-edge model state, check at negedge.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] d,
                     input logic lz, input logic bl);
    int          idx;
    logic [15:0] sh;
    logic [3:0]  nib;
    logic [6:0]  lit;
    logic [3:0]  oh;
    logic [6:0]  exp_seg;
    logic        exp_dot;
    logic [3:0]  exp_an;
    load = ld; value = v; dp = d; lzb_en = lz; blank = bl;
    idx = (e / SD) % NDIG;
    sh  = m_val >> (4 * idx);
    nib = sh[3:0];
    lit = (lz && idx > 0 && sh == 16'h0) ? 7'b0 : hex_lit[nib];
    oh  = 4'b0001 << idx;
    exp_seg = ~lit;
    exp_dot = ~m_dp[idx];
    exp_an  = bl ? 4'hf : ~oh;
    @(posedge clk);
    m_frame = 0;
    if ((e % FRAME) == FRAME - 1 && ld) begin
      m_val = v; m_dp = d; m_pend = 0; m_frame = 1;
    end else if ((e % FRAME) == FRAME - 1 && m_pend) begin
      m_val = p_val; m_dp = p_dp; m_pend = 0; m_frame = 1;
    end else if (ld) begin
      p_val = v; p_dp = d; m_pend = 1;
    end
    e++;
    @(negedge clk);
    chk("seg", 16'(seg), 16'(exp_seg));
    chk("dot", 16'(dot), 16'(exp_dot));
    chk("an", 16'(an), 16'(exp_an));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("frame", 16'(frame), 16'(m_frame));
  endtask

  task automatic chk_reset_state();
    chk("rst_seg", 16'(seg), 16'h7f);
    chk("rst_dot", 16'(dot), 16'h1);
    chk("rst_an", 16'(an), 16'hf);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_frame", 16'(frame), 16'h0);
  endtask

  initial begin
    logic [15:0] rv;
    logic [3:0]  rd;
    logic        rlz, rbl;
    rst_n = 0; load = 0; value = '0; dp = '0; lzb_en = 0; blank = 0;
    m_reset();
    #12;
    chk_reset_state();
    @(negedge clk);
    rst_n = 1;

    // Basic scan of 12AF, including the reset-time "0" on digit 0 before commit.
    cyc(1, 16'h12af, 4'h0, 0, 0);
    repeat (40) cyc(0, 16'h12af, 4'h0, 0, 0);

    // Load during the digit-1 slot; waits for the next wrap.
    while (((e / SD) % NDIG) != 1) cyc(0, 16'h0, 4'h0, 0, 0);
    cyc(1, 16'h3c5d, 4'h0, 0, 0);
    repeat (36) cyc(0, 16'h0, 4'h0, 0, 0);

    // Leading-zero blanking.
    cyc(1, 16'h0050, 4'h0, 1, 0);
    repeat (36) cyc(0, 16'h0, 4'h0, 1, 0);
    cyc(1, 16'h0000, 4'h0, 1, 0);
    repeat (36) cyc(0, 16'h0, 4'h0, 1, 0);

    // Load exactly on the commit cycle while 1111 is pending.
    while ((e % FRAME) != 5) cyc(0, 16'h0, 4'h0, 0, 0);
    cyc(1, 16'h1111, 4'h0, 0, 0);
    while ((e % FRAME) != FRAME - 1) cyc(0, 16'h0, 4'h0, 0, 0);
    cyc(1, 16'h2222, 4'h0, 0, 0);
    repeat (20) cyc(0, 16'h0, 4'h0, 0, 0);

    // Global blank, then decimal point on digit 2.
    repeat (10) cyc(0, 16'h0, 4'h0, 0, 1);
    cyc(1, 16'h8888, 4'b0100, 0, 0);
    repeat (36) cyc(0, 16'h0, 4'h0, 0, 0);

    // Reset mid-frame with data pending.
    cyc(1, 16'h7777, 4'hf, 0, 0);
    repeat (3) cyc(0, 16'h0, 4'h0, 0, 0);
    #2 rst_n = 0;
    #1 chk_reset_state();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (20) cyc(0, 16'h0, 4'h0, 0, 0);

    // Randomised traffic: sparse and back-to-back loads, live lzb/blank toggling.
    rlz = 0; rbl = 0;
    for (int i = 0; i < 600; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv[15:8] = 8'h00;
      rd = 4'($urandom);
      if ($urandom_range(0, 19) == 0) rlz = ~rlz;
      if ($urandom_range(0, 29) == 0) rbl = ~rbl;
      cyc(($urandom_range(0, 7) == 0), rv, rd, rlz, rbl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed driver for a multi-digit 7-segment display. It replaces per-digit combinational hex decoders with one time-shared decoder and a scan counter, so one segment bus serves NDIG digits. Display data is double-buffered: loads commit only at frame boundaries, which prevents torn frames. It adds per-digit decimal points, leading-zero blanking, global blanking and selectable output polarity, and sits between datapath registers and the board's segment/anode pins.

Parameters:
NDIG, 4, number of digits scanned (2..8)
SCAN_DIV, 50000, clock cycles each digit stays active (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment lit when driven 0; 0 = lit when driven 1
AN_ACTIVE_LOW, 1, 1 = digit enabled when anode driven 0; 0 = enabled when driven 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NDIG  hex nibbles; nibble k = value[4k+3:4k]; digit 0 is least significant / rightmost
dp  in  NDIG  decimal point request per digit
load  in  1  one-cycle strobe; captures value/dp into pending buffer
lzb_en  in  1  leading-zero blanking enable (sampled live)
blank  in  1  global blank (sampled live)
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dot  out  1  decimal point segment, same polarity as seg
an  out  NDIG  digit enables, one-hot when active, polarity per AN_ACTIVE_LOW
pending  out  1  pending buffer holds uncommitted data
frame  out  1  one-cycle pulse when a commit occurs

Behaviour:
- Reset (async, rst_n=0): scan counter=0, idx=0, display and pending buffers=0, pending=0, frame=0. seg/dot are driven to the unlit level and an to all-disabled, at the polarity given by the parameters.
- Scan counter: cnt counts 0..SCAN_DIV-1 and wraps. tick = (cnt==SCAN_DIV-1). On tick, idx advances 0→1→…→NDIG-1→0.
- Outputs are registered from idx and the display buffer, so they lag idx by 1 cycle. After reset release, the first clock edge enables digit 0.
- Decode of the selected nibble (active-high lit pattern {g..a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking: when lzb_en=1, digit k is blanked if nibbles NDIG-1..k are all zero. Digit 0 is never blanked by this rule. A blanked digit still has its anode enabled, with seg unlit, and its dot follows dp.
- Global blank: when blank=1, an goes all-disabled on the next edge. The counter and idx keep running, and loads and commits still occur.
- Load: on load=1, pending buffer <= {value, dp} and pending <= 1. Back-to-back loads overwrite the buffer; the last load wins.
- Commit point: tick with idx==NDIG-1 (the wrap to digit 0). If pending=1, then display buffer <= pending buffer, pending <= 0, frame <= 1 for one cycle. Otherwise nothing happens and frame stays 0.
- Simultaneous load and commit: the incoming value/dp go directly to the display buffer, pending <= 0, frame=1. No data is lost.
- Worst-case load-to-display latency is NDIG*SCAN_DIV+1 cycles.
- Reset mid-frame returns everything to the reset state immediately and discards pending data.

Test Plan:
1. NDIG=4, SCAN_DIV=4, active-low: reset, then load value=16'h12AF, dp=0 → after first commit (frame=1), an cycles 1110,1101,1011,0111 every 4 cycles. seg shows F=0001110, A=0001000, 2=0100100, 1=1111001.
2. Commit timing: with pending=0, idx=1, pulse load → pending=1 until the wrap tick; frame pulses exactly once, and digits show the new data only from the next digit-0 slot.
3. Leading zeros: value=16'h0050, lzb_en=1 → digits 3 and 2 have seg=1111111 with anode enabled; digits 1 and 0 show 5 and 0. value=16'h0000 → digit 0 shows 0, the others are blank.
4. Load at exactly the commit cycle, with pending holding 16'h1111 and new value 16'h2222 → display shows 2222, pending=0, one frame pulse.
5. blank=1 for 10 cycles → an=1111 from the next edge; idx keeps advancing. Release → the correct digit for the current idx appears. dp=4'b0100 → dot=0 only in the digit 2 slot.
6. Assert rst_n=0 mid-frame with pending=1 → outputs go to unlit/disabled asynchronously, pending=0; after release, digit 0 shows 0.
